// File: rtl/ctrl_mem_load.sv
// Loads the X and F vectors from two valid/ready streams into their memories, then holds conv_start until conv_done.
// Memory writes are combinational on the handshake; conv_start rises one cycle after the last required word.
// Readies come from state and full flags only; both are held low during CONV and while reset is asserted.
module ctrl_mem_load #(
    parameter int F_MEM_SIZE       = 4,
    parameter int X_MEM_SIZE       = 8,
    parameter int X_MEM_ADDR_WIDTH = 3,
    parameter int F_MEM_ADDR_WIDTH = 2,
    parameter int T                = 8
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic [T-1:0]                s_data_in_x,
    input  logic                        s_valid_x,
    output logic                        s_ready_x,
    input  logic [T-1:0]                s_data_in_f,
    input  logic                        s_valid_f,
    output logic                        s_ready_f,
    output logic                        x_wr_en,
    output logic [X_MEM_ADDR_WIDTH-1:0] x_addr,
    output logic [T-1:0]                x_data,
    output logic                        f_wr_en,
    output logic [F_MEM_ADDR_WIDTH-1:0] f_addr,
    output logic [T-1:0]                f_data,
    output logic                        conv_start,
    input  logic                        conv_done
);

    localparam logic [0:0] LOAD = 1'b0;
    localparam logic [0:0] CONV = 1'b1;

    localparam logic [X_MEM_ADDR_WIDTH-1:0] X_LAST = X_MEM_ADDR_WIDTH'(X_MEM_SIZE - 1);
    localparam logic [F_MEM_ADDR_WIDTH-1:0] F_LAST = F_MEM_ADDR_WIDTH'(F_MEM_SIZE - 1);

    logic [0:0]                  state;
    logic                        x_full;
    logic                        f_full;
    logic [X_MEM_ADDR_WIDTH-1:0] x_cnt;
    logic [F_MEM_ADDR_WIDTH-1:0] f_cnt;
    logic                        x_hs;
    logic                        f_hs;
    logic                        x_full_nxt;
    logic                        f_full_nxt;

    // Gating with reset keeps the write enables low while reset is held, even with valid asserted.
    assign s_ready_x = reset && (state == LOAD) && !x_full;
    assign s_ready_f = reset && (state == LOAD) && !f_full;

    assign x_hs = s_valid_x && s_ready_x;
    assign f_hs = s_valid_f && s_ready_f;

    assign x_wr_en = x_hs;
    assign x_addr  = x_cnt;
    assign x_data  = s_data_in_x;
    assign f_wr_en = f_hs;
    assign f_addr  = f_cnt;
    assign f_data  = s_data_in_f;

    assign x_full_nxt = x_full || (x_hs && (x_cnt == X_LAST));
    assign f_full_nxt = f_full || (f_hs && (f_cnt == F_LAST));

    assign conv_start = (state == CONV);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state  <= LOAD;
            x_full <= 1'b0;
            f_full <= 1'b0;
            x_cnt  <= '0;
            f_cnt  <= '0;
        end else begin
            case (state)
                LOAD: begin
                    // Counts wrap explicitly so non-power-of-2 sizes never exceed the memory depth.
                    if (x_hs) x_cnt <= (x_cnt == X_LAST) ? '0 : x_cnt + 1'b1;
                    if (f_hs) f_cnt <= (f_cnt == F_LAST) ? '0 : f_cnt + 1'b1;
                    x_full <= x_full_nxt;
                    f_full <= f_full_nxt;
                    if (x_full_nxt && f_full_nxt) state <= CONV;
                end
                default: begin
                    if (conv_done) begin
                        state  <= LOAD;
                        x_full <= 1'b0;
                        f_full <= 1'b0;
                        x_cnt  <= '0;
                        f_cnt  <= '0;
                    end
                end
            endcase
        end
    end

endmodule

// File: tb/tb_ctrl_mem_load.sv
// Bench for ctrl_mem_load: stream drivers push expected writes into queues, a negedge monitor pops and compares them.
module tb_ctrl_mem_load;

    logic       clk = 1'b0;
    logic       reset;
    logic [7:0] s_data_in_x, s_data_in_f;
    logic       s_valid_x, s_valid_f;
    logic       s_ready_x, s_ready_f;
    logic       x_wr_en, f_wr_en;
    logic [2:0] x_addr;
    logic [1:0] f_addr;
    logic [7:0] x_data, f_data;
    logic       conv_start;
    logic       conv_done;

    int checks = 0;
    int errors = 0;

    typedef struct packed { logic [2:0] addr; logic [7:0] data; } xexp_t;
    typedef struct packed { logic [1:0] addr; logic [7:0] data; } fexp_t;
    xexp_t xq[$];
    fexp_t fq[$];

    ctrl_mem_load dut (
        .clk(clk), .reset(reset),
        .s_data_in_x(s_data_in_x), .s_valid_x(s_valid_x), .s_ready_x(s_ready_x),
        .s_data_in_f(s_data_in_f), .s_valid_f(s_valid_f), .s_ready_f(s_ready_f),
        .x_wr_en(x_wr_en), .x_addr(x_addr), .x_data(x_data),
        .f_wr_en(f_wr_en), .f_addr(f_addr), .f_data(f_data),
        .conv_start(conv_start), .conv_done(conv_done)
    );

    always #5 clk = ~clk;

    // Scoreboard monitor: every write must match the oldest outstanding expected word.
    always @(negedge clk) begin
        if (x_wr_en === 1'b1) begin
            checks++;
            if (xq.size() == 0) begin
                errors++;
                $display("FAIL x_write_unexpected: got addr=%0d data=%0d, required no write", x_addr, x_data);
            end else begin
                xexp_t e;
                e = xq.pop_front();
                if ({x_addr, x_data} !== {e.addr, e.data}) begin
                    errors++;
                    $display("FAIL x_write: got addr=%0d data=%0d, required addr=%0d data=%0d", x_addr, x_data, e.addr, e.data);
                end
            end
        end
        if (f_wr_en === 1'b1) begin
            checks++;
            if (fq.size() == 0) begin
                errors++;
                $display("FAIL f_write_unexpected: got addr=%0d data=%0d, required no write", f_addr, f_data);
            end else begin
                fexp_t e;
                e = fq.pop_front();
                if ({f_addr, f_data} !== {e.addr, e.data}) begin
                    errors++;
                    $display("FAIL f_write: got addr=%0d data=%0d, required addr=%0d data=%0d", f_addr, f_data, e.addr, e.data);
                end
            end
        end
    end

    // Drivers enter and leave 1 time unit after a rising edge; last_t records the edge of the final handshake.
    task automatic drive_x(input int start, input int n, input int base, input int pre, input bit gaps, output time last_t);
        bit hs;
        int guard;
        last_t = 0;
        repeat (pre) begin @(posedge clk); #1; end
        for (int i = 0; i < n; i++) begin
            xexp_t e;
            if (gaps) begin
                s_valid_x = 1'b0;
                repeat ($urandom_range(0, 1)) begin @(posedge clk); #1; end
            end
            s_valid_x = 1'b1;
            s_data_in_x = 8'(base + i);
            e.addr = 3'(start + i);
            e.data = 8'(base + i);
            xq.push_back(e);
            hs = 1'b0;
            guard = 0;
            while (!hs && guard < 100) begin
                @(negedge clk);
                hs = (s_ready_x === 1'b1);
                checks++;
                if (conv_start !== 1'b0) begin
                    errors++;
                    $display("FAIL conv_start_early_x: got %b while X word %0d pending, required 0", conv_start, start + i);
                end
                @(posedge clk);
                last_t = $time;
                #1;
                guard++;
            end
            if (!hs) begin
                errors++;
                $display("FAIL x_timeout: got no handshake for word %0d, required one within 100 cycles", start + i);
            end
        end
        s_valid_x = 1'b0;
    endtask

    task automatic drive_f(input int start, input int n, input int base, input int pre, input bit gaps, output time last_t);
        bit hs;
        int guard;
        last_t = 0;
        repeat (pre) begin @(posedge clk); #1; end
        for (int i = 0; i < n; i++) begin
            fexp_t e;
            if (gaps) begin
                s_valid_f = 1'b0;
                repeat ($urandom_range(0, 1)) begin @(posedge clk); #1; end
            end
            s_valid_f = 1'b1;
            s_data_in_f = 8'(base + i);
            e.addr = 2'(start + i);
            e.data = 8'(base + i);
            fq.push_back(e);
            hs = 1'b0;
            guard = 0;
            while (!hs && guard < 100) begin
                @(negedge clk);
                hs = (s_ready_f === 1'b1);
                checks++;
                if (conv_start !== 1'b0) begin
                    errors++;
                    $display("FAIL conv_start_early_f: got %b while F word %0d pending, required 0", conv_start, start + i);
                end
                @(posedge clk);
                last_t = $time;
                #1;
                guard++;
            end
            if (!hs) begin
                errors++;
                $display("FAIL f_timeout: got no handshake for word %0d, required one within 100 cycles", start + i);
            end
        end
        s_valid_f = 1'b0;
    endtask

    task automatic check_round_done(input string name);
        checks++;
        if (conv_start !== 1'b1) begin
            errors++;
            $display("FAIL %s_conv_start: got %b one cycle after last handshake, required 1", name, conv_start);
        end
        checks++;
        if (xq.size() != 0 || fq.size() != 0) begin
            errors++;
            $display("FAIL %s_scoreboard: got %0d X and %0d F writes missing, required 0", name, xq.size(), fq.size());
        end
    endtask

    task automatic pulse_done(input string name);
        conv_done = 1'b1;
        @(posedge clk); #1;
        conv_done = 1'b0;
        checks++;
        if ({conv_start, s_ready_x, s_ready_f} !== 3'b011) begin
            errors++;
            $display("FAIL %s_after_done: got conv_start/rdy_x/rdy_f=%b, required 011", name, {conv_start, s_ready_x, s_ready_f});
        end
    endtask

    task automatic test_reset();
        reset = 1'b0;
        s_valid_x = 1'b1; s_valid_f = 1'b1;
        s_data_in_x = 8'h00; s_data_in_f = 8'h00;
        conv_done = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        checks++;
        if ({conv_start, x_wr_en, f_wr_en} !== 3'b000) begin
            errors++;
            $display("FAIL reset_outputs: got conv_start/x_wr/f_wr=%b, required 000", {conv_start, x_wr_en, f_wr_en});
        end
        s_valid_x = 1'b0; s_valid_f = 1'b0;
        reset = 1'b1;
        @(negedge clk);
        checks++;
        if ({s_ready_x, s_ready_f, conv_start} !== 3'b110) begin
            errors++;
            $display("FAIL reset_release: got rdy_x/rdy_f/conv_start=%b, required 110", {s_ready_x, s_ready_f, conv_start});
        end
        @(posedge clk); #1;
    endtask

    task automatic test_back_to_back();
        time tx, tf;
        fork
            drive_x(0, 8, 1, 0, 1'b0, tx);
            begin
                drive_f(0, 4, 1, 0, 1'b0, tf);
                checks++;
                if (s_ready_f !== 1'b0) begin
                    errors++;
                    $display("FAIL b2b_ready_f_drop: got %b after 4 F handshakes, required 0", s_ready_f);
                end
            end
        join
        check_round_done("b2b");
        pulse_done("b2b");
    endtask

    task automatic test_simultaneous();
        time tx, tf;
        fork
            drive_x(0, 8, 8'h20, 0, 1'b0, tx);
            drive_f(0, 4, 8'h30, 4, 1'b0, tf);
        join
        checks++;
        if (tx != tf) begin
            errors++;
            $display("FAIL simul_same_edge: got last X at %0t and last F at %0t, required equal", tx, tf);
        end
        check_round_done("simul");
        pulse_done("simul");
    endtask

    task automatic test_random_gaps();
        time tx, tf;
        for (int r = 0; r < 3; r++) begin
            fork
                drive_x(0, 8, 8'h40 + r * 16, 0, 1'b1, tx);
                drive_f(0, 4, 8'h80 + r * 16, 0, 1'b1, tf);
            join
            check_round_done("gaps");
            if (r < 2) pulse_done("gaps");
        end
    endtask

    task automatic test_conv_hold();
        s_valid_x = 1'b1; s_valid_f = 1'b1;
        s_data_in_x = 8'hEE; s_data_in_f = 8'hEF;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            checks++;
            if ({s_ready_x, s_ready_f, x_wr_en, f_wr_en, conv_start} !== 5'b00001) begin
                errors++;
                $display("FAIL conv_hold: got rdy_x/rdy_f/x_wr/f_wr/conv_start=%b at cycle %0d, required 00001",
                         {s_ready_x, s_ready_f, x_wr_en, f_wr_en, conv_start}, i);
            end
        end
        @(posedge clk); #1;
        s_valid_x = 1'b0; s_valid_f = 1'b0;
        pulse_done("conv_hold");
    endtask

    task automatic test_reset_mid_load();
        time tx, tf;
        fork
            drive_x(0, 5, 8'h50, 0, 1'b0, tx);
            drive_f(0, 2, 8'h60, 0, 1'b0, tf);
        join
        s_valid_x = 1'b1; s_data_in_x = 8'h5F;
        #1;
        checks++;
        if (x_wr_en !== 1'b1 || x_addr !== 3'd5) begin
            errors++;
            $display("FAIL pre_reset_write: got x_wr=%b addr=%0d, required 1 at addr 5", x_wr_en, x_addr);
        end
        reset = 1'b0;
        #1;
        checks++;
        if ({x_wr_en, f_wr_en, conv_start} !== 3'b000) begin
            errors++;
            $display("FAIL async_reset: got x_wr/f_wr/conv_start=%b without a clock edge, required 000", {x_wr_en, f_wr_en, conv_start});
        end
        s_valid_x = 1'b0;
        @(posedge clk); #1;
        reset = 1'b1;
        fork
            drive_x(0, 8, 8'h70, 0, 1'b0, tx);
            drive_f(0, 4, 8'h78, 0, 1'b0, tf);
        join
        check_round_done("reset_reload");
        pulse_done("reset_reload");
    endtask

    task automatic test_done_in_load();
        time tx, tf;
        fork
            drive_x(0, 3, 8'h90, 0, 1'b0, tx);
            drive_f(0, 1, 8'hA0, 0, 1'b0, tf);
        join
        conv_done = 1'b1;
        @(posedge clk); #1;
        conv_done = 1'b0;
        checks++;
        if ({conv_start, s_ready_x, s_ready_f, x_addr, f_addr} !== {3'b011, 3'd3, 2'd1}) begin
            errors++;
            $display("FAIL done_in_load: got conv_start/rdy_x/rdy_f=%b x_addr=%0d f_addr=%0d, required 011 3 1",
                     {conv_start, s_ready_x, s_ready_f}, x_addr, f_addr);
        end
        fork
            drive_x(3, 5, 8'h93, 0, 1'b0, tx);
            drive_f(1, 3, 8'hA1, 0, 1'b0, tf);
        join
        check_round_done("done_in_load");
        pulse_done("done_in_load");
    endtask

    initial begin
        test_reset();
        test_back_to_back();
        test_simultaneous();
        test_random_gaps();
        test_conv_hold();
        test_reset_mid_load();
        test_done_in_load();
        repeat (2) @(posedge clk);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/ctrl_mem_load.md
CTRL_MEM_LOAD -- requirements
Module: ctrl_mem_load

Interface
REQ-001 The block SHALL take these parameters (name, default, meaning):
- F_MEM_SIZE, 4, filter vector length.
- X_MEM_SIZE, 8, input vector length; X_MEM_SIZE > F_MEM_SIZE.
- X_MEM_ADDR_WIDTH, 3, X memory address width.
- F_MEM_ADDR_WIDTH, 2, F memory address width.
- T, 8, data word width.

REQ-002 The block SHALL have these ports (name, direction, width, meaning):
- clk, in, 1, the single clock; all state changes on its rising edge.
- reset, in, 1, asynchronous active-low reset; 0 = reset asserted.
- s_data_in_x, in, T, X stream data.
- s_valid_x, in, 1, X stream valid.
- s_ready_x, out, 1, X stream ready.
- s_data_in_f, in, T, F stream data.
- s_valid_f, in, 1, F stream valid.
- s_ready_f, out, 1, F stream ready.
- x_wr_en, out, 1, X memory write enable.
- x_addr, out, X_MEM_ADDR_WIDTH, X memory write address.
- x_data, out, T, X memory write data.
- f_wr_en, out, 1, F memory write enable.
- f_addr, out, F_MEM_ADDR_WIDTH, F memory write address.
- f_data, out, T, F memory write data.
- conv_start, out, 1, level-high: both memories are loaded and convolution may run.
- conv_done, in, 1, single-cycle pulse from the output controller: last result accepted.

Function
REQ-003 The block SHALL implement a two-state FSM, LOAD and CONV; it SHALL enter LOAD on reset.

REQ-004 In LOAD, s_ready_x SHALL equal !x_full and s_ready_f SHALL equal !f_full. Both are decoded from registers only, with no combinational path from s_valid_*.

REQ-005 In CONV, s_ready_x and s_ready_f SHALL both be 0.

REQ-006 An X handshake (s_valid_x && s_ready_x) SHALL drive x_wr_en=1, x_data=s_data_in_x and x_addr=current X count, combinationally in the same cycle.

REQ-007 An F handshake SHALL behave the same way on the f_* signals; x_wr_en and f_wr_en SHALL be 0 in every other cycle.

REQ-008 The X and F streams SHALL be accepted independently and concurrently; a stall on one stream SHALL NOT block the other.

REQ-009 On each X handshake the X count SHALL increment by 1. On the handshake at count X_MEM_SIZE-1, x_full SHALL be set and the count SHALL return to 0. The count SHALL never hold a value >= X_MEM_SIZE, including for non-power-of-2 sizes.

REQ-010 The F count and f_full SHALL behave the same way, with F_MEM_SIZE as the limit.

REQ-011 Transition LOAD->CONV SHALL occur on the edge where both full conditions hold after that edge. This includes the case where the final X and final F handshakes occur in the same cycle.

REQ-012 conv_start SHALL equal (state==CONV). It SHALL therefore rise exactly one cycle after the final required handshake and stay high for the whole convolution.

REQ-013 In CONV, conv_done=1 SHALL cause transition CONV->LOAD and SHALL clear x_full, f_full and both counts on the same edge. conv_start SHALL be 0 in the following cycle.

REQ-014 conv_done SHALL be ignored in LOAD.

REQ-015 conv_start SHALL be low for at least X_MEM_SIZE cycles between rounds, so the downstream rising-edge detector sees a fresh edge every round.

REQ-016 Stream data SHALL be stored in arrival order: element i of a vector goes to address i.

Reset
REQ-017 reset=0 SHALL asynchronously force:
- state=LOAD;
- counts=0; x_full=0; f_full=0;
- conv_start=0; x_wr_en=0; f_wr_en=0.

REQ-018 After reset deasserts, s_ready_x=1 and s_ready_f=1 SHALL hold from the first clock on which reset=1.

REQ-019 Reset asserted mid-LOAD or mid-CONV SHALL discard the partial round. After release the next round SHALL restart at address 0.

Verification
REQ-020 Back-to-back load: X=1..8 and F=1..4 with valid held high -> x_addr 0..7, f_addr 0..3 written in order; s_ready_f drops after 4 F handshakes; conv_start rises the cycle after the 8th X handshake.

REQ-021 Simultaneous finish: F delayed so the 4th F and 8th X handshakes share a cycle -> conv_start rises exactly one cycle later.

REQ-022 Random valid gaps on both streams (~50% duty) -> every word is written exactly once, at the correct address, and conv_start is 0 until both vectors are complete.

REQ-023 In CONV, drive s_valid_x=s_valid_f=1 for 10 cycles -> ready stays 0 and no wr_en pulses; then pulse conv_done -> conv_start=0 next cycle, readies=1, and the next round writes from address 0.

REQ-024 Reset pulse after 5 X and 2 F words -> all outputs clear immediately (without waiting for a clock edge); a full reload then produces conv_start after 8 X and 4 F handshakes.

REQ-025 conv_done pulsed during LOAD -> counts, full flags and state are unchanged.
